// File: rtl/mux_41_arb.sv
// Four-requester round-robin arbiter with an output mux. A grant lasts until the
// requester drops its request or MAX_BEATS transfers complete. One IDLE cycle follows each grant.
module mux_41_arb #(
   parameter int DW        = 1,
   parameter int MAX_BEATS = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [3:0]    req,
   input  logic [DW-1:0] din_a,
   input  logic [DW-1:0] din_b,
   input  logic [DW-1:0] din_c,
   input  logic [DW-1:0] din_d,
   output logic [3:0]    in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [3:0]    gnt,
   output logic          s1,
   output logic          s2
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [3:0] LAST_BEAT = 4'(MAX_BEATS - 1);

   state_t        state_q, state_d;
   logic [3:0]    gnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [1:0]    winner;
   logic [1:0]    cand;
   logic          found;
   logic          beat;
   logic          release_now;
   logic [DW-1:0] lane;

   // Search order starts just after the last released index, so it wraps to ptr itself last.
   always_comb begin
      winner = ptr_q;
      cand   = '0;
      found  = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cand = ptr_q + 2'(i);
         if (!found && req[cand]) begin
            winner = cand;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      case (sel_q)
         2'd0:    lane = din_a;
         2'd1:    lane = din_b;
         2'd2:    lane = din_c;
         default: lane = din_d;
      endcase
   end

   assign out_valid   = (state_q == GRANT) && req[sel_q];
   assign out_data    = (|gnt) ? lane : '0;
   assign in_ready    = gnt & {4{out_ready}};
   assign beat        = out_valid && out_ready;
   assign release_now = (state_q == GRANT) && (!req[sel_q] || (beat && (cnt_q == LAST_BEAT)));
   assign s1          = sel_q[1];
   assign s2          = sel_q[0];

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            gnt_d = 4'b0000;
            if (found) begin
               state_d = GRANT;
               gnt_d   = 4'b0001 << winner;
               sel_d   = winner;
               cnt_d   = 4'd0;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d = IDLE;
               gnt_d   = 4'b0000;
               ptr_d   = sel_q;
            end else if (beat) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt     <= 4'b0000;
         sel_q   <= 2'b00;
         ptr_q   <= 2'b11;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         gnt     <= gnt_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux_41_arb.sv
// Bench for mux_41_arb: directed scenarios plus randomized traffic checked against
// a transaction-level arbitration model, on a MAX_BEATS=4 and a MAX_BEATS=1 instance.
module tb_mux_41_arb;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req1 = '0, req2 = '0;
   logic       ordy1 = 1'b0, ordy2 = 1'b0;
   logic [7:0] da = 8'h11, db = 8'h22, dc = 8'h33, dd = 8'h44;

   logic [3:0] ir1, g1, ir2, g2;
   logic       ov1, s1a, s2a, ov2, s1b, s2b;
   logic [7:0] od1, od2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mux_41_arb #(.DW(8), .MAX_BEATS(4)) u1 (
      .clk(clk), .rst_n(rst_n), .req(req1),
      .din_a(da), .din_b(db), .din_c(dc), .din_d(dd),
      .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(ordy1),
      .gnt(g1), .s1(s1a), .s2(s2a));

   mux_41_arb #(.DW(8), .MAX_BEATS(1)) u2 (
      .clk(clk), .rst_n(rst_n), .req(req2),
      .din_a(da), .din_b(db), .din_c(dc), .din_d(dd),
      .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(ordy2),
      .gnt(g2), .s1(s1b), .s2(s2b));

   // Transaction-level model: who owns the output, beats taken, last released requester.
   typedef struct packed {
      int own;
      int bts;
      int lst;
      int sel;
   } mst_t;

   mst_t m1, m2;

   function automatic mst_t mstep(mst_t s, logic [3:0] r, logic rdy, int maxb);
      mst_t n;
      bit   done;
      n    = s;
      done = 0;
      if (s.own < 0) begin
         for (int i = 1; i <= 4; i++) begin
            if (!done && r[(s.lst + i) % 4]) begin
               n.own = (s.lst + i) % 4;
               n.sel = n.own;
               n.bts = 0;
               done  = 1;
            end
         end
      end else if (!r[s.own]) begin
         n.lst = s.own;
         n.own = -1;
      end else if (rdy) begin
         n.bts = s.bts + 1;
         if (n.bts == maxb) begin
            n.lst = s.own;
            n.own = -1;
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] lane_of(int i);
      case (i)
         0:       return da;
         1:       return db;
         2:       return dc;
         default: return dd;
      endcase
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m1 <= '{own: -1, bts: 0, lst: 3, sel: 0};
         m2 <= '{own: -1, bts: 0, lst: 3, sel: 0};
      end else begin
         m1 <= mstep(m1, req1, ordy1, 4);
         m2 <= mstep(m2, req2, ordy2, 1);
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      req1 = '0; req2 = '0; ordy1 = 1'b0; ordy2 = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req1 = 4'hF; ordy1 = 1'b1; req2 = 4'hF; ordy2 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({g1, ir1, ov1, od1, s1a, s2a} !== 19'd0) begin
         errors++;
         $display("FAIL reset_u1 gnt=%b in_ready=%b valid=%b data=%h sel=%b%b want all zero", g1, ir1, ov1, od1, s1a, s2a);
      end
      checks++;
      if ({g2, ir2, ov2, od2, s1b, s2b} !== 19'd0) begin
         errors++;
         $display("FAIL reset_u2 gnt=%b in_ready=%b valid=%b data=%h sel=%b%b want all zero", g2, ir2, ov2, od2, s1b, s2b);
      end
      rst_n = 1'b1;
      #1;
      checks++;
      if (g1 !== 4'b0000 || ov1 !== 1'b0) begin
         errors++;
         $display("FAIL reset_release gnt=%b valid=%b want 0000/0 before first edge", g1, ov1);
      end
      step();
      checks++;
      if (g1 !== 4'b0001 || {s1a, s2a} !== 2'b00) begin
         errors++;
         $display("FAIL reset_first_winner gnt=%b sel=%b%b want 0001/00", g1, s1a, s2a);
      end
   endtask

   task automatic test_single();
      logic [3:0] exp_g [6];
      exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001};
      apply_reset();
      da = 8'hA5;
      req1 = 4'b0001; ordy1 = 1'b1;
      for (int n = 0; n < 6; n++) begin
         step();
         checks++;
         if (g1 !== exp_g[n] || {s1a, s2a} !== 2'b00 || od1 !== ((exp_g[n] != 0) ? 8'hA5 : 8'h00)) begin
            errors++;
            $display("FAIL single cyc=%0d gnt=%b sel=%b%b data=%h want gnt=%b sel=00", n + 1, g1, s1a, s2a, od1, exp_g[n]);
         end
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] eg;
      apply_reset();
      req1 = 4'b1111; ordy1 = 1'b1;
      for (int n = 0; n < 25; n++) begin
         step();
         eg = ((n % 5) < 4) ? 4'(1 << ((n / 5) % 4)) : 4'b0000;
         checks++;
         if (g1 !== eg || in_ready_mismatch(ir1, eg, ordy1)) begin
            errors++;
            $display("FAIL round_robin cyc=%0d gnt=%b in_ready=%b want gnt=%b", n + 1, g1, ir1, eg);
         end
      end
   endtask

   function automatic bit in_ready_mismatch(logic [3:0] ir, logic [3:0] eg, logic rdy);
      return ir !== (rdy ? eg : 4'b0000);
   endfunction

   task automatic test_drop();
      apply_reset();
      req1 = 4'b0100; ordy1 = 1'b1;
      repeat (3) step();
      req1 = 4'b1011;
      #1;
      checks++;
      if (ov1 !== 1'b0 || g1 !== 4'b0100) begin
         errors++;
         $display("FAIL drop_valid valid=%b gnt=%b want 0/0100", ov1, g1);
      end
      step();
      checks++;
      if (g1 !== 4'b0000 || {s1a, s2a} !== 2'b10) begin
         errors++;
         $display("FAIL drop_release gnt=%b sel=%b%b want 0000/10", g1, s1a, s2a);
      end
      step();
      checks++;
      if (g1 !== 4'b1000 || {s1a, s2a} !== 2'b11) begin
         errors++;
         $display("FAIL drop_next_winner gnt=%b sel=%b%b want 1000/11", g1, s1a, s2a);
      end
   endtask

   task automatic test_stall();
      apply_reset();
      req1 = 4'b0010; ordy1 = 1'b0;
      for (int n = 0; n < 6; n++) begin
         step();
         checks++;
         if (g1 !== 4'b0010 || ir1 !== 4'b0000 || ov1 !== 1'b1) begin
            errors++;
            $display("FAIL stall cyc=%0d gnt=%b in_ready=%b valid=%b want 0010/0000/1", n, g1, ir1, ov1);
         end
      end
      ordy1 = 1'b1;
      for (int n = 0; n < 4; n++) begin
         step();
         checks++;
         if (g1 !== ((n < 3) ? 4'b0010 : 4'b0000)) begin
            errors++;
            $display("FAIL stall_resume beat=%0d gnt=%b want %b", n + 1, g1, (n < 3) ? 4'b0010 : 4'b0000);
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      req1 = 4'b0100; ordy1 = 1'b1;
      repeat (3) step();
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (g1 !== 4'b0000 || ov1 !== 1'b0 || ir1 !== 4'b0000 || od1 !== 8'h00 || {s1a, s2a} !== 2'b00) begin
         errors++;
         $display("FAIL reset_mid gnt=%b valid=%b in_ready=%b data=%h sel=%b%b want zeros", g1, ov1, ir1, od1, s1a, s2a);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         checks++;
         if (g1 !== ((n < 4) ? 4'b0100 : 4'b0000)) begin
            errors++;
            $display("FAIL reset_mid_regrant cyc=%0d gnt=%b want %b", n, g1, (n < 4) ? 4'b0100 : 4'b0000);
         end
      end
   endtask

   task automatic test_single_beat();
      logic [3:0] exp_g [5];
      logic [7:0] exp_d [5];
      exp_g = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b0010};
      apply_reset();
      db = 8'hB6; dc = 8'hC7;
      exp_d = '{8'hB6, 8'h00, 8'hC7, 8'h00, 8'hB6};
      req2 = 4'b0110; ordy2 = 1'b1;
      for (int n = 0; n < 5; n++) begin
         step();
         checks++;
         if (g2 !== exp_g[n] || od2 !== exp_d[n]) begin
            errors++;
            $display("FAIL single_beat cyc=%0d gnt=%b data=%h want %b/%h", n + 1, g2, od2, exp_g[n], exp_d[n]);
         end
      end
   endtask

   task automatic test_random();
      logic [3:0] eg, ei, pg1, pg2;
      logic       ev;
      logic [7:0] ed;
      apply_reset();
      pg1 = '0; pg2 = '0;
      for (int n = 0; n < 600; n++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) == 0) req1 = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) req2 = 4'($urandom_range(0, 15));
         ordy1 = ($urandom_range(0, 3) != 0);
         ordy2 = ($urandom_range(0, 3) != 0);
         da = 8'($urandom); db = 8'($urandom); dc = 8'($urandom); dd = 8'($urandom);
         #1;
         eg = (m1.own >= 0) ? 4'(1 << m1.own) : 4'b0000;
         ev = (m1.own >= 0) && req1[m1.own];
         ed = (m1.own >= 0) ? lane_of(m1.own) : 8'h00;
         ei = ordy1 ? eg : 4'b0000;
         checks++;
         if ({g1, ir1, ov1, od1, s1a, s2a} !== {eg, ei, ev, ed, 2'(m1.sel)}) begin
            errors++;
            $display("FAIL random_u1 cyc=%0d gnt=%b ir=%b v=%b d=%h sel=%b%b want %b %b %b %h %0d",
                     n, g1, ir1, ov1, od1, s1a, s2a, eg, ei, ev, ed, m1.sel);
         end
         eg = (m2.own >= 0) ? 4'(1 << m2.own) : 4'b0000;
         ev = (m2.own >= 0) && req2[m2.own];
         ed = (m2.own >= 0) ? lane_of(m2.own) : 8'h00;
         ei = ordy2 ? eg : 4'b0000;
         checks++;
         if ({g2, ir2, ov2, od2, s1b, s2b} !== {eg, ei, ev, ed, 2'(m2.sel)}) begin
            errors++;
            $display("FAIL random_u2 cyc=%0d gnt=%b ir=%b v=%b d=%h sel=%b%b want %b %b %b %h %0d",
                     n, g2, ir2, ov2, od2, s1b, s2b, eg, ei, ev, ed, m2.sel);
         end
         checks++;
         if (!$onehot0(g1) || (pg1 != 0 && g1 != 0 && g1 != pg1) || !$onehot0(g2) || (pg2 != 0 && g2 != 0 && g2 != pg2)) begin
            errors++;
            $display("FAIL grant_switch cyc=%0d gnt1 %b->%b gnt2 %b->%b want one-hot, no lane change", n, pg1, g1, pg2, g2);
         end
         pg1 = g1; pg2 = g2;
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_drop();
      test_stall();
      test_reset_mid();
      test_single_beat();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
